// File: rtl/qed_dup_scheduler.sv
// QED duplicate scheduler: forwards the IFU stream to decode, queues
// duplicable instructions and replays them with regs moved to x16-x31.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   qed_ena            QED mode enable
//   qed_exec_dup       request to switch to the duplicate phase
//   ifu_instruction    instruction from IFU
//   ifu_valid          IFU valid
//   ifu_ready          IFU ready
//   qed_instruction    instruction to decode
//   qed_valid          decode valid
//   qed_ready          decode ready
//   qed_is_dup         output word is a replayed duplicate
//   fifo_count         queued entries
//   fifo_full          queue holds DEPTH entries
module qed_dup_scheduler #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qed_ena,
  input  logic             qed_exec_dup,
  input  logic [31:0]      ifu_instruction,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  output logic [31:0]      qed_instruction,
  output logic             qed_valid,
  input  logic             qed_ready,
  output logic             qed_is_dup,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_PASS,
    S_ORIG,
    S_DUP
  } state_t;

  state_t           r_state;
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]       w_iop;
  logic             w_can;
  logic [31:0]      w_head;
  logic [6:0]       w_hop;
  logic             w_hr, w_hi, w_hl, w_hs;
  logic             w_hb, w_hlui, w_hau;
  logic [31:0]      w_remap;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_nx;

  function automatic logic [4:0] f_up(
    input logic [4:0] f
  );
    return (f == 5'd0) ? 5'd0 : (f | 5'b10000);
  endfunction

  assign w_iop = ifu_instruction[6:0];
  assign w_can = (w_iop == 7'b0110011) |
                 (w_iop == 7'b0010011) |
                 (w_iop == 7'b0000011) |
                 (w_iop == 7'b0100011) |
                 (w_iop == 7'b1100011) |
                 (w_iop == 7'b0110111) |
                 (w_iop == 7'b0010111);

  assign w_head = r_mem[r_rptr];
  assign w_hop  = w_head[6:0];
  assign w_hr   = (w_hop == 7'b0110011);
  assign w_hi   = (w_hop == 7'b0010011);
  assign w_hl   = (w_hop == 7'b0000011);
  assign w_hs   = (w_hop == 7'b0100011);
  assign w_hb   = (w_hop == 7'b1100011);
  assign w_hlui = (w_hop == 7'b0110111);
  assign w_hau  = (w_hop == 7'b0010111);

  // S and B keep bits [11:7]: they are immediate bits there
  always_comb begin
    w_remap = w_head;
    if (w_hr | w_hi | w_hl | w_hlui | w_hau)
      w_remap[11:7] = f_up(w_head[11:7]);
    if (w_hr | w_hi | w_hl | w_hs | w_hb)
      w_remap[19:15] = f_up(w_head[19:15]);
    if (w_hr | w_hs | w_hb)
      w_remap[24:20] = f_up(w_head[24:20]);
  end

  assign w_full = (r_cnt == CNT_W'(DEPTH));

  always_comb begin
    qed_instruction = NOP;
    qed_valid       = 1'b0;
    ifu_ready       = 1'b0;
    qed_is_dup      = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_PASS: begin
          qed_instruction = ifu_instruction;
          qed_valid       = ifu_valid;
          ifu_ready       = qed_ready;
        end
        S_ORIG: begin
          qed_instruction = ifu_instruction;
          qed_valid       = ifu_valid & ~w_full;
          ifu_ready       = qed_ready & ~w_full;
        end
        S_DUP: begin
          qed_instruction = w_remap;
          qed_valid       = (r_cnt != '0);
          qed_is_dup      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_push = (r_state == S_ORIG) & ifu_valid &
                  ifu_ready & w_can;
  assign w_pop  = (r_state == S_DUP) & qed_valid &
                  qed_ready;
  assign w_cnt_nx = r_cnt + CNT_W'(w_push) -
                    CNT_W'(w_pop);

  assign fifo_count = r_cnt;
  assign fifo_full  = w_full;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= ifu_instruction;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PASS;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nx;
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case (r_state)
        S_PASS: begin
          if (qed_ena)
            r_state <= S_ORIG;
        end
        S_ORIG: begin
          // queued entries are drained before PASS
          if (!qed_ena)
            r_state <= (w_cnt_nx == '0) ? S_PASS : S_DUP;
          else if ((qed_exec_dup ||
                    w_cnt_nx == CNT_W'(DEPTH)) &&
                   w_cnt_nx != '0)
            r_state <= S_DUP;
        end
        S_DUP: begin
          if (r_cnt == '0 || (w_pop && r_cnt == CNT_W'(1)))
            r_state <= qed_ena ? S_ORIG : S_PASS;
        end
        default: r_state <= S_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: scoreboard of originals and
// duplicates, checked as decode accepts each word.
module tb_qed_dup_scheduler;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             qed_ena;
  logic             qed_exec_dup;
  logic [31:0]      ifu_instruction;
  logic             ifu_valid;
  logic             ifu_ready;
  logic [31:0]      qed_instruction;
  logic             qed_valid;
  logic             qed_ready;
  logic             qed_is_dup;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q_orig[$];
  logic [31:0] q_dup[$];

  qed_dup_scheduler #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .qed_ena        (qed_ena),
    .qed_exec_dup   (qed_exec_dup),
    .ifu_instruction(ifu_instruction),
    .ifu_valid      (ifu_valid),
    .ifu_ready      (ifu_ready),
    .qed_instruction(qed_instruction),
    .qed_valid      (qed_valid),
    .qed_ready      (qed_ready),
    .qed_is_dup     (qed_is_dup),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [4:0] up(input logic [4:0] f);
    if (f == 5'd0) return 5'd0;
    return {1'b1, f[3:0]};
  endfunction

  // reference model of the duplicate word, per opcode
  function automatic logic [31:0] m_dup(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    case (w[6:0])
      7'b0110011: begin
        r[11:7] = up(w[11:7]);
        r[19:15] = up(w[19:15]);
        r[24:20] = up(w[24:20]);
      end
      7'b0010011, 7'b0000011: begin
        r[11:7] = up(w[11:7]);
        r[19:15] = up(w[19:15]);
      end
      7'b0100011, 7'b1100011: begin
        r[19:15] = up(w[19:15]);
        r[24:20] = up(w[24:20]);
      end
      7'b0110111, 7'b0010111: r[11:7] = up(w[11:7]);
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [6:0] ops [7];
    logic [31:0] w;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011;
    ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b0110111;
    ops[6] = 7'b0010111;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 6)];
    return w;
  endfunction

  // decode-side monitor
  always @(negedge clk) begin
    if (rst_n && qed_valid && qed_ready) begin
      if (qed_is_dup) begin
        if (q_dup.size() == 0)
          chk("dup_unexp", q_dup.size(), 1);
        else
          chk("dup_word", qed_instruction, q_dup.pop_front());
      end else begin
        if (q_orig.size() == 0)
          chk("orig_unexp", q_orig.size(), 1);
        else
          chk("orig_word", qed_instruction, q_orig.pop_front());
      end
    end
    if (rst_n && ifu_valid && ifu_ready)
      chk("push_full", fifo_full, 0);
  end

  task automatic send(input logic [31:0] w, input bit dup);
    bit done;
    done = 0;
    ifu_instruction = w;
    ifu_valid = 1'b1;
    q_orig.push_back(w);
    if (dup) q_dup.push_back(m_dup(w));
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ifu_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("send_to", ifu_ready, 1);
    ifu_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && fifo_count != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", fifo_count, 0);
  endtask

  task automatic pulse_dup();
    qed_exec_dup = 1'b1;
    @(posedge clk); #1;
    qed_exec_dup = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0;
    qed_ready = 1'b1;
    ifu_valid = 1'b0;
    qed_ena = 1'b0;
    qed_exec_dup = 1'b0;
    ifu_instruction = '0;
    for (int i = 0; i < 3; i++) begin
      qed_ena = 1'($urandom);
      qed_exec_dup = 1'($urandom);
      ifu_valid = 1'($urandom);
      qed_ready = 1'($urandom);
      ifu_instruction = $urandom;
      @(negedge clk);
      chk("rst_ifu_rdy", ifu_ready, 0);
      chk("rst_qvalid", qed_valid, 0);
      chk("rst_isdup", qed_is_dup, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_instr", qed_instruction, 32'h13);
      @(posedge clk); #1;
    end
    qed_ena = 1'b0;
    qed_exec_dup = 1'b0;
    ifu_valid = 1'b0;
    qed_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // passthrough
    ifu_instruction = 32'h002081B3;
    ifu_valid = 1'b1;
    @(negedge clk);
    chk("pass_instr", qed_instruction, 32'h002081B3);
    chk("pass_isdup", qed_is_dup, 0);
    ifu_valid = 1'b0;
    @(posedge clk); #1;
    send(32'h002081B3, 0);
    chk("pass_count", fifo_count, 0);

    // single replay
    qed_ena = 1'b1;
    @(posedge clk); #1;
    send(32'h002081B3, 1);
    chk("rep_count", fifo_count, 1);
    pulse_dup();
    @(negedge clk);
    chk("rep_instr", qed_instruction, 32'h012889B3);
    chk("rep_isdup", qed_is_dup, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rep_empty", fifo_count, 0);
    chk("rep_back", qed_is_dup, 0);
    @(posedge clk); #1;

    // fill, auto replay, second round wraps pointers
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++)
        send(rnd_ins(), 1);
      @(negedge clk);
      chk("full_flag", fifo_full, 1);
      chk("full_rdy", ifu_ready, 0);
      chk("full_dup", qed_is_dup, 1);
      @(posedge clk); #1;
      wait_drain();
      chk("full_q", q_dup.size(), 0);
    end

    // filtering and x0
    send(32'h0000006F, 0);
    send(32'h00000013, 1);
    chk("filt_count", fifo_count, 1);
    pulse_dup();
    @(negedge clk);
    chk("nop_dup", qed_instruction, 32'h00000013);
    @(posedge clk); #1;
    wait_drain();

    // backpressure with qed_ena dropped
    for (int i = 0; i < 3; i++) send(rnd_ins(), 1);
    qed_ready = 1'b0;
    qed_ena = 1'b0;
    pulse_dup();
    @(negedge clk);
    held = qed_instruction;
    chk("bp_valid", qed_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", qed_instruction, held);
      chk("bp_cnt", fifo_count, 3);
    end
    @(posedge clk); #1;
    qed_ready = 1'b1;
    wait_drain();
    send(rnd_ins(), 0);
    chk("bp_pass", fifo_count, 0);

    // reset during DUP
    qed_ena = 1'b1;
    @(posedge clk); #1;
    send(rnd_ins(), 1);
    send(rnd_ins(), 1);
    qed_ready = 1'b0;
    pulse_dup();
    @(negedge clk);
    chk("mr_indup", qed_is_dup, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q_dup.delete();
    qed_ena = 1'b0;
    #1;
    chk("mr_count", fifo_count, 0);
    chk("mr_instr", qed_instruction, 32'h13);
    @(posedge clk); #1;
    rst_n = 1'b1;
    qed_ready = 1'b1;
    @(negedge clk);
    chk("mr_isdup", qed_is_dup, 0);
    @(posedge clk); #1;
    send(rnd_ins(), 0);
    chk("mr_pass", fifo_count, 0);
    chk("orig_left", q_orig.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
